// File: rtl/coef_quantizer_if.sv
// Beat-level bus between the coefficient quantizer and its neighbours:
// input handshake with per-beat controls, output handshake, overflow telemetry.
interface coef_quantizer_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 12,
    parameter int LANES = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             mode;
    logic                   sat_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       sat_flags;
    logic [15:0]            sat_count;
    logic                   clr_count;

    modport slave (
        input  in_valid, in_data, mode, sat_en, out_ready, clr_count,
        output in_ready, out_valid, out_data, sat_flags, sat_count
    );

    modport master (
        output in_valid, in_data, mode, sat_en, out_ready, clr_count,
        input  in_ready, out_valid, out_data, sat_flags, sat_count
    );
endinterface

// File: rtl/coef_quantizer.sv
// Multi-lane fixed-point to integer quantizer: stage 1 rounds, stage 2 detects
// overflow and saturates or wraps; elastic two-stage valid/ready pipeline.
module coef_quantizer #(
    parameter int IN_W      = 18,
    parameter int FRAC_BITS = 6,
    parameter int OUT_W     = 12,
    parameter int LANES     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    coef_quantizer_if.slave  bus
);
    localparam int RW = IN_W - FRAC_BITS + 1;
    localparam int EW = ((RW > OUT_W) ? RW : OUT_W) + 1;
    localparam logic signed [EW-1:0] MAX_V   = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic [OUT_W-1:0]     SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [RW-1:0]   rnd        [LANES];
    logic signed [RW-1:0]   s1_data_q  [LANES];
    logic signed [RW-1:0]   s1_data_d  [LANES];
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_sat_en_q, s1_sat_en_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES*OUT_W-1:0] out_data_q, out_data_d, lane_out;
    logic [LANES-1:0]       sat_flags_q, sat_flags_d, lane_ovf;
    logic [15:0]            sat_count_q, sat_count_d;
    logic [16:0]            flag_pop, count_sum;
    logic                   adv, s1_load;

    // Stage 2 may load when it is empty or being drained this cycle.
    assign adv     = !out_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || adv;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [IN_W-1:0] x;
            logic signed [EW-1:0]   ext;
            logic [OUT_W-1:0]       lo;

            assign x = bus.in_data[gi*IN_W +: IN_W];

            if (FRAC_BITS == 0) begin : g_nofrac
                assign rnd[gi] = RW'(x);
            end else begin : g_frac
                localparam logic [FRAC_BITS-1:0] HALF = FRAC_BITS'(1) << (FRAC_BITS - 1);
                logic signed [RW-1:0]  q;
                logic [FRAC_BITS-1:0]  r;
                logic                  up;

                assign q = RW'(x >>> FRAC_BITS);
                assign r = x[FRAC_BITS-1:0];

                always_comb begin
                    up = 1'b0;
                    case (bus.mode)
                        2'b01:   up = (r >= HALF);
                        2'b10:   up = (r > HALF) || ((r == HALF) && q[0]);
                        default: up = 1'b0;
                    endcase
                end

                // q is at most 2^(RW-2)-1, so the increment cannot wrap RW bits.
                assign rnd[gi] = q + RW'(up);
            end

            assign ext          = EW'(s1_data_q[gi]);
            assign lane_ovf[gi] = (ext > MAX_V) || (ext < ~MAX_V);

            always_comb begin
                lo = ext[OUT_W-1:0];
                if (lane_ovf[gi] && s1_sat_en_q) begin
                    lo = ext[EW-1] ? SAT_MIN : SAT_MAX;
                end
            end

            assign lane_out[gi*OUT_W +: OUT_W] = lo;
        end
    endgenerate

    always_comb begin
        flag_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            flag_pop = flag_pop + 17'(sat_flags_q[i]);
        end
        count_sum = 17'(sat_count_q) + flag_pop;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sat_en_d = s1_sat_en_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_flags_d = sat_flags_q;
        sat_count_d = sat_count_q;

        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sat_en_d = bus.sat_en;
                s1_data_d   = rnd;
            end
        end

        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = lane_out;
                sat_flags_d = lane_ovf;
            end
        end

        // Clear takes priority over a delivery in the same cycle.
        if (bus.clr_count) begin
            sat_count_d = '0;
        end else if (out_valid_q && bus.out_ready) begin
            sat_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sat_en_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flags_q <= '0;
            sat_count_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_data_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sat_en_q <= s1_sat_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flags_q <= sat_flags_d;
            sat_count_q <= sat_count_d;
            s1_data_q   <= s1_data_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flags = sat_flags_q;
    assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_coef_quantizer.sv
// Randomized scoreboard bench for coef_quantizer with an arithmetic reference
// model, plus directed rounding, saturation, stall, counter and reset cases.
module tb_coef_quantizer;
    localparam int IN_W  = 18;
    localparam int FRAC  = 6;
    localparam int OUT_W = 12;
    localparam int LANES = 8;

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       flags;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;

    exp_t exp_q[$];
    int   cnt_model = 0;
    logic hold_v = 1'b0;
    logic [LANES*OUT_W-1:0] hold_data;
    logic [LANES-1:0]       hold_flags;

    coef_quantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus ();

    coef_quantizer #(.IN_W(IN_W), .FRAC_BITS(FRAC), .OUT_W(OUT_W), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: floor-divide by 2^FRAC, then apply the rounding rule on the remainder.
    function automatic void model_lane(input logic [IN_W-1:0] xb, input logic [1:0] m,
                                       input logic se, output logic [OUT_W-1:0] o,
                                       output logic f);
        int x, q, r, v, half, maxv, minv;
        x    = int'($signed(xb));
        half = 1 << (FRAC - 1);
        q    = x >>> FRAC;
        r    = x - q * (1 << FRAC);
        v    = q;
        if (m == 2'b01 && r >= half) v = q + 1;
        if (m == 2'b10 && (r > half || (r == half && (q % 2) != 0))) v = q + 1;
        maxv = (1 << (OUT_W - 1)) - 1;
        minv = -(1 << (OUT_W - 1));
        f = (v > maxv) || (v < minv);
        if (f && se) o = (v > 0) ? OUT_W'(maxv) : OUT_W'(minv);
        else         o = OUT_W'(v);
    endfunction

    function automatic exp_t model_beat(input logic [LANES*IN_W-1:0] d, input logic [1:0] m,
                                        input logic se);
        exp_t e;
        logic [OUT_W-1:0] o;
        logic f;
        for (int l = 0; l < LANES; l++) begin
            model_lane(d[l*IN_W +: IN_W], m, se, o, f);
            e.data[l*OUT_W +: OUT_W] = o;
            e.flags[l] = f;
        end
        return e;
    endfunction

    function automatic logic [IN_W-1:0] rand_lane();
        logic [IN_W-1:0] v;
        case ($urandom % 4)
            0:       v = IN_W'($urandom);
            1:       v = 18'h1FFFF - IN_W'($urandom % 200);
            2:       v = 18'h20000 + IN_W'($urandom % 200);
            default: v = IN_W'($urandom % 1024) - 18'd512;
        endcase
        return v;
    endfunction

    // Monitor: samples at the falling edge; pops/compares deliveries, pushes accepts.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        int   pop;
        if (!rst_n) begin
            exp_q.delete();
            cnt_model = 0;
            hold_v = 1'b0;
            check("rst_out_valid", 128'(bus.out_valid), 128'(0));
            check("rst_out_data",  128'(bus.out_data),  128'(0));
            check("rst_sat_flags", 128'(bus.sat_flags), 128'(0));
            check("rst_sat_count", 128'(bus.sat_count), 128'(0));
        end else begin
            n = exp_q.size();
            check("in_ready", 128'(bus.in_ready), 128'(!(n == 2 && !bus.out_ready)));
            check("sat_count", 128'(bus.sat_count), 128'(cnt_model));
            if (hold_v) begin
                check("stall_valid", 128'(bus.out_valid), 128'(1));
                check("stall_data",  128'(bus.out_data),  128'(hold_data));
                check("stall_flags", 128'(bus.sat_flags), 128'(hold_flags));
            end
            hold_v     = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            hold_flags = bus.sat_flags;
            pop = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (n == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_beat: got data %h with no beat outstanding", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data",  128'(bus.out_data),  128'(e.data));
                    check("sat_flags", 128'(bus.sat_flags), 128'(e.flags));
                    pop = $countones(e.flags);
                end
            end
            if (bus.clr_count) cnt_model = 0;
            else if (cnt_model + pop > 65535) cnt_model = 65535;
            else cnt_model = cnt_model + pop;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_beat(bus.in_data, bus.mode, bus.sat_en));
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send_beat(input logic [LANES*IN_W-1:0] d, input logic [1:0] m, input logic se);
        int waited = 0;
        bus.in_data  = d;
        bus.mode     = m;
        bus.sat_en   = se;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            waited++;
            idle(1);
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        idle(2);
    endtask

    task automatic directed(input string nm, input logic [IN_W-1:0] x, input logic [1:0] m,
                            input logic se, input logic [OUT_W-1:0] eo, input logic ef);
        logic [LANES*IN_W-1:0] d;
        d = '0;
        d[IN_W-1:0] = x;
        send_beat(d, m, se);
        @(negedge clk);
        check({nm, "_lat1"}, 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        check({nm, "_valid"}, 128'(bus.out_valid), 128'(1));
        check({nm, "_lane0"}, 128'(bus.out_data[OUT_W-1:0]), 128'(eo));
        check({nm, "_flag0"}, 128'(bus.sat_flags[0]), 128'(ef));
        idle(2);
    endtask

    function automatic logic [LANES*IN_W-1:0] rand_beat();
        logic [LANES*IN_W-1:0] d;
        for (int l = 0; l < LANES; l++) d[l*IN_W +: IN_W] = rand_lane();
        return d;
    endfunction

    initial begin
        logic [LANES*IN_W-1:0] ovf_beat;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'b00;
        bus.sat_en    = 1'b1;
        bus.clr_count = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        rst_n = 1'b1;
        idle(2);

        directed("h15_trunc", 18'h00060, 2'b00, 1'b1, 12'h001, 1'b0);
        directed("h15_hup",   18'h00060, 2'b01, 1'b1, 12'h002, 1'b0);
        directed("h15_heven", 18'h00060, 2'b10, 1'b1, 12'h002, 1'b0);
        directed("h25_trunc", 18'h000A0, 2'b00, 1'b1, 12'h002, 1'b0);
        directed("h25_hup",   18'h000A0, 2'b01, 1'b1, 12'h003, 1'b0);
        directed("h25_heven", 18'h000A0, 2'b10, 1'b1, 12'h002, 1'b0);
        directed("n15_trunc", 18'h3FFA0, 2'b00, 1'b1, 12'hFFE, 1'b0);
        directed("n15_hup",   18'h3FFA0, 2'b01, 1'b1, 12'hFFF, 1'b0);
        directed("n15_heven", 18'h3FFA0, 2'b10, 1'b1, 12'hFFE, 1'b0);
        directed("mode11",    18'h000A0, 2'b11, 1'b1, 12'h002, 1'b0);
        directed("max_sat",   18'h1FFFF, 2'b01, 1'b1, 12'h7FF, 1'b1);
        directed("max_wrap",  18'h1FFFF, 2'b01, 1'b0, 12'h800, 1'b1);
        directed("min_trunc", 18'h20000, 2'b00, 1'b1, 12'h800, 1'b0);
        directed("slice",     18'h2B5C7, 2'b00, 1'b0, 12'hAD7, 1'b0);

        // Reset with two beats in flight must flush them immediately.
        send_beat(rand_beat(), 2'b01, 1'b1);
        send_beat(rand_beat(), 2'b01, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_sat_count", 128'(bus.sat_count), 128'(0));
        idle(2);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst_no_beat", 128'(bus.out_valid), 128'(0));
        end
        idle(1);

        // Randomized traffic with random backpressure, gaps and counter clears.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            bus.clr_count = ($urandom % 20) == 0;
            send_beat(rand_beat(), 2'($urandom % 4), 1'($urandom % 2));
            bus.clr_count = 1'b0;
            if ($urandom % 3 == 0) idle($urandom % 3);
        end
        drain();

        // Ten beats against an alternating out_ready.
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) send_beat(rand_beat(), 2'($urandom % 3), 1'b1);
        drain();

        // Saturating counter: all-overflow beats up to FFF8, then past the top.
        rdy_mode = 0;
        idle(2);
        bus.clr_count = 1'b1;
        idle(1);
        bus.clr_count = 1'b0;
        for (int l = 0; l < LANES; l++) ovf_beat[l*IN_W +: IN_W] = 18'h1FFFF;
        for (int i = 0; i < 8191; i++) send_beat(ovf_beat, 2'b01, 1'b1);
        drain();
        check("count_fff8", 128'(bus.sat_count), 128'(16'hFFF8));
        send_beat(ovf_beat, 2'b01, 1'b1);
        send_beat(ovf_beat, 2'b01, 1'b0);
        drain();
        check("count_ffff", 128'(bus.sat_count), 128'(16'hFFFF));
        send_beat(ovf_beat, 2'b01, 1'b1);
        idle(1);
        check("count_hold_ffff", 128'(bus.sat_count), 128'(16'hFFFF));
        send_beat(ovf_beat, 2'b01, 1'b1);
        idle(1);
        bus.clr_count = 1'b1;
        @(negedge clk);
        check("clr_with_delivery_valid", 128'(bus.out_valid), 128'(1));
        @(posedge clk);
        #2;
        bus.clr_count = 1'b0;
        @(negedge clk);
        check("clr_wins", 128'(bus.sat_count), 128'(0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/coef_quantizer.md
COEF_QUANTIZER -- requirements
Module: coef_quantizer

Interface
REQ-001 The block SHALL have parameter IN_W, default 18, meaning signed fixed-point coefficient width per lane.
REQ-002 The block SHALL have parameter FRAC_BITS, default 6, meaning fractional bits in each input coefficient (0 <= FRAC_BITS < IN_W).
REQ-003 The block SHALL have parameter OUT_W, default 12, meaning signed integer output width per lane.
REQ-004 The block SHALL have parameter LANES, default 8, meaning coefficients per beat.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid  in  1  input beat valid.
REQ-008 The block SHALL have port in_ready  out  1  block can accept a beat.
REQ-009 The block SHALL have port in_data  in  LANES*IN_W  packed coefficients, lane 0 in LSBs.
REQ-010 The block SHALL have port mode  in  2  rounding: 00 truncate (floor), 01 round-half-up (toward +inf), 10 round-half-even, 11 treated as 00.
REQ-011 The block SHALL have port sat_en  in  1  1 = saturate on overflow, 0 = wrap (keep low OUT_W bits).
REQ-012 The block SHALL have port out_valid  out  1  output beat valid.
REQ-013 The block SHALL have port out_ready  in  1  downstream accepts beat.
REQ-014 The block SHALL have port out_data  out  LANES*OUT_W  packed integer results, lane 0 in LSBs.
REQ-015 The block SHALL have port sat_flags  out  LANES  per-lane overflow indicator, aligned with out_data.
REQ-016 The block SHALL have port sat_count  out  16  count of overflowed lanes delivered.
REQ-017 The block SHALL have port clr_count  in  1  synchronous clear of sat_count.

Function
REQ-018 mode and sat_en SHALL be sampled per beat at input acceptance (in_valid && in_ready) and travel with that beat.
REQ-019 Per lane: q = x >>> FRAC_BITS (arithmetic), r = x[FRAC_BITS-1:0], h = 2^(FRAC_BITS-1); computed at IN_W-FRAC_BITS+1 bits.
REQ-020 Truncate: result q; round-half-up: q+1 if r >= h, else q; round-half-even: q+1 if r > h, q+q[0] if r == h, else q.
REQ-021 With FRAC_BITS = 0 all modes SHALL pass x unchanged to the overflow stage.
REQ-022 Overflow: result outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flags[lane] = 1 regardless of sat_en.
REQ-023 On overflow with sat_en=1, lane output SHALL clamp to the nearest bound; with sat_en=0, low OUT_W bits.
REQ-024 Two-stage pipeline: stage 1 registers round result, stage 2 registers saturated output; out_valid asserts 2 cycles after acceptance edge when unstalled.
REQ-025 Stage 2 loads when !out_valid || out_ready; stage 1 advances under the same condition; in_ready = !s1_valid || (!out_valid || out_ready).
REQ-026 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-027 While out_valid && !out_ready, out_data, sat_flags and out_valid SHALL hold stable; no beat dropped or duplicated.
REQ-028 sat_count SHALL add popcount(sat_flags) on each out_valid && out_ready, saturating at 16'hFFFF.
REQ-029 clr_count SHALL zero sat_count next cycle; clear wins over a simultaneous increment.
REQ-030 Defaults, mode 00, no overflow SHALL equal plain bit-slice x[17:6] per lane.

Reset
REQ-031 While rst_n = 0: s1_valid, out_valid = 0, in_ready = 1 after reset, out_data = 0, sat_flags = 0, sat_count = 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight beats immediately; no partial beat emitted after release.

Verification
REQ-033 Lane0 = 18'h00060 (1.5), modes 00/01/10 -> out 1 / 2 / 2, flags 0, latency 2 cycles.
REQ-034 Lane0 = 18'h000A0 (2.5) -> 2 / 3 / 2; lane0 = 18'h3FFA0 (-1.5) -> -2 / -1 / -2.
REQ-035 Lane0 = 18'h1FFFF, mode 01: sat_en=1 -> 12'h7FF, flag 1, sat_count +1; sat_en=0 -> 12'h800, flag 1; lane0 = 18'h20000 mode 00 -> 12'h800, flag 0.
REQ-036 Stream 10 beats, out_ready toggled 1010...: all 10 emerge in order, values stable during stall, in_ready low only when both stages full and stalled.
REQ-037 8-lane all-overflow beats until sat_count = 16'hFFF8, then 2 more beats -> 16'hFFFF held; clr_count with concurrent delivery -> 0.
REQ-038 rst_n pulsed low with 2 beats in flight -> out_valid 0 immediately, sat_count 0, no stale beat after release.
